// File: rtl/ysyx_23060061_ifu.sv
// Instruction fetch unit: owns the PC, issues one fetch at a time to
// instruction memory, and holds the fetched word until decode takes it.
// Redirects from execute override every transition. A request that is
// already in flight when a redirect arrives is marked for dropping.
module ysyx_23060061_ifu #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            imem_rsp_err,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] inst_pc,
  output logic            inst_fault,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [31:0]     fetch_count
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;
  logic            drop;
  logic            drop_next;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] target_pc;
  logic            deliver;
  logic            retire;

  // Redirect targets are forced onto a word boundary.
  assign target_pc = redirect_pc & ~{{(XLEN-2){1'b0}}, 2'b11};

  // A response is only captured when it belongs to the current PC.
  assign deliver = (state == S_WAIT) && imem_rsp_valid && !drop && !redirect_valid;

  // The held instruction only counts as delivered if no redirect kills it.
  assign retire  = (state == S_OUT) && inst_ready && !redirect_valid;

  // State register together with the drop flag for an orphaned request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_REQ;
      drop  <= 1'b0;
    end else begin
      state <= state_next;
      drop  <= drop_next;
    end
  end

  // Next-state logic; redirect takes precedence in every state.
  always_comb begin
    state_next = state;
    drop_next  = drop;
    case (state)
      S_REQ: begin
        if (imem_req_ready) begin
          state_next = S_WAIT;
          drop_next  = redirect_valid;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          if (imem_rsp_valid) begin
            state_next = S_REQ;
            drop_next  = 1'b0;
          end else begin
            drop_next  = 1'b1;
          end
        end else if (imem_rsp_valid) begin
          state_next = drop ? S_REQ : S_OUT;
          drop_next  = 1'b0;
        end
      end
      S_OUT: begin
        if (redirect_valid || inst_ready) begin
          state_next = S_REQ;
        end
      end
      default: begin
        state_next = S_REQ;
        drop_next  = 1'b0;
      end
    endcase
  end

  // Handshake outputs decoded from the state, held low during reset.
  always_comb begin
    imem_req_valid = !rst && (state == S_REQ);
    inst_valid     = !rst && (state == S_OUT);
    imem_req_addr  = pc;
  end

  // PC, output instruction register and delivered-instruction counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      inst        <= 32'd0;
      inst_pc     <= '0;
      inst_fault  <= 1'b0;
      fetch_count <= 32'd0;
    end else begin
      if (redirect_valid) begin
        pc <= target_pc;
      end else if (retire) begin
        pc <= pc + XLEN'(4);
      end
      if (deliver) begin
        inst       <= imem_rsp_data;
        inst_fault <= imem_rsp_err;
        inst_pc    <= pc;
      end
      if (retire) begin
        fetch_count <= fetch_count + 32'd1;
      end
    end
  end

endmodule
